// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared definitions for the forwarding / hazard logic.
//   FWD_*     : EX operand mux select encodings (11 is never driven)
//   hz_rd_t   : register address as held in a hazard slot; wide enough
//               for any supported REG_AW, narrower addresses are zero-extended
//   hz_slot_t : per-stage destination tracking {valid, rd, reg_write, mem_read}
package pipeline_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    localparam int RD_MAX_W = 8;

    typedef logic [RD_MAX_W-1:0] hz_rd_t;

    typedef struct packed {
        logic   valid;
        hz_rd_t rd;
        logic   reg_write;
        logic   mem_read;
    } hz_slot_t;

endpackage

// File: rtl/fwd_select.sv
// fwd_select: combinational priority compare for one EX operand.
//   rs  in  source register of the consumer in ID
//   ex  in  slot of the instruction currently in EX
//   mem in  slot of the instruction currently in MEM
//   sel out operand mux select (FWD_EXMEM > FWD_WB > FWD_REGFILE)
module fwd_select
    import pipeline_pkg::*;
(
    input  hz_rd_t     rs,
    input  hz_slot_t   ex,
    input  hz_slot_t   mem,
    output logic [1:0] sel
);

    logic ex_hit;
    logic mem_hit;

    // A load in EX has no ALU result to forward; the hazard unit stalls
    // instead and the value is picked up from MEM/WB one cycle later.
    assign ex_hit  = ex.valid & ex.reg_write & (ex.rd != '0) & (ex.rd == rs) & ~ex.mem_read;
    assign mem_hit = mem.valid & mem.reg_write & (mem.rd != '0) & (mem.rd == rs);

    always_comb begin
        sel = FWD_REGFILE;
        if (ex_hit)
            sel = FWD_EXMEM;
        else if (mem_hit)
            sel = FWD_WB;
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding and load-use hazard controller for the
// 5-stage pipeline. Tracks the EX/MEM/WB destination slots internally.
//   clk, reset       clock, async active-high reset
//   id_*             decoded fields of the instruction in ID
//   flush            taken branch/jump, kills the ID instruction
//   fwd_a_sel/_b_sel registered EX operand mux selects
//   stall            hold PC and IF/ID (combinational)
//   bubble_ex        ID/EX loads a NOP on the next edge (combinational)
//   stall_count      stall-cycle counter, only built with `define STALL_CNT_EN
module fwd_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              bubble_ex,
    output logic [31:0]       stall_count
);

    localparam int NUM_OPS = 2;

    hz_slot_t ex_s, mem_s, wb_s;
    hz_slot_t id_s;
    logic     load_use;
    logic     unused_wb;

    hz_rd_t [NUM_OPS-1:0]     rs;
    logic   [NUM_OPS-1:0][1:0] sel_nxt;

    assign rs[0] = hz_rd_t'(id_rs1);
    assign rs[1] = hz_rd_t'(id_rs2);

    assign id_s = '{valid: id_valid, rd: hz_rd_t'(id_rd),
                    reg_write: id_reg_write, mem_read: id_mem_read};

    assign load_use = id_valid & ex_s.valid & ex_s.mem_read & ex_s.reg_write
                    & (ex_s.rd != '0) & ((ex_s.rd == rs[0]) | (ex_s.rd == rs[1]));

    // Flush outranks the stall: the dependent instruction is being killed.
    assign stall     = load_use & ~flush;
    assign bubble_ex = stall | flush;

    // WB is tracked for pipeline completeness; nothing forwards from it.
    assign unused_wb = ^wb_s;

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        fwd_select u_sel (
            .rs  (rs[i]),
            .ex  (ex_s),
            .mem (mem_s),
            .sel (sel_nxt[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_s      <= '0;
            mem_s     <= '0;
            wb_s      <= '0;
            fwd_a_sel <= FWD_REGFILE;
            fwd_b_sel <= FWD_REGFILE;
        end else begin
            wb_s  <= mem_s;
            mem_s <= ex_s;
            ex_s  <= bubble_ex ? hz_slot_t'('0) : id_s;
            // Selects travel with the consumer into EX, so a bubble gets 00.
            fwd_a_sel <= bubble_ex ? FWD_REGFILE : sel_nxt[0];
            fwd_b_sel <= bubble_ex ? FWD_REGFILE : sel_nxt[1];
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (stall && stall_count != 32'hFFFF_FFFF)
            stall_count <= stall_count + 32'd1;
    end
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_reg_write, id_mem_read, flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall, bubble_ex;
    logic [31:0] stall_count;

    fwd_hazard_ctrl #(.REG_AW(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .bubble_ex(bubble_ex), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reference model: the two most recently issued instructions
    // (index 0 = now in EX, 1 = now in MEM) plus the currently registered selects.
    typedef struct { bit v; int rd; bit rw; bit mr; } instr_t;
    typedef struct { bit stall; bit bub; bit [1:0] sa; bit [1:0] sb; bit [31:0] cnt; } exp_t;

    instr_t   hist[2];
    exp_t     q[$];
    bit [1:0] m_sa, m_sb;
    bit [31:0] m_cnt;
    int       tests = 0;
    int       failed = 0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", n, $time, got, exp);
        end
    endtask

    function automatic bit [1:0] fwd_src(input int rs);
        // Youngest producer wins; a load still in EX cannot supply a value.
        for (int i = 0; i < 2; i++) begin
            if (hist[i].v && hist[i].rw && hist[i].rd != 0 && hist[i].rd == rs) begin
                if (i == 0 && hist[i].mr) continue;
                return (i == 0) ? 2'b10 : 2'b01;
            end
        end
        return 2'b00;
    endfunction

    task automatic model_reset();
        hist[0] = '{0, 0, 0, 0};
        hist[1] = '{0, 0, 0, 0};
        m_sa = 0; m_sb = 0; m_cnt = 0;
    endtask

    // Drives one ID-stage instruction for one cycle and records what the
    // DUT must show during that cycle.
    task automatic issue(input bit v, input int rs1, input int rs2, input int rd,
                         input bit rw, input bit mr, input bit fl);
        bit lu, es, eb;
        exp_t e;
        @(posedge clk); #1;
        id_valid = v; id_rs1 = rs1[4:0]; id_rs2 = rs2[4:0]; id_rd = rd[4:0];
        id_reg_write = rw; id_mem_read = mr; flush = fl;
        lu = v && hist[0].v && hist[0].mr && hist[0].rw && hist[0].rd != 0
             && (hist[0].rd == rs1 || hist[0].rd == rs2);
        es = lu && !fl;
        eb = es || fl;
        e = '{es, eb, m_sa, m_sb, m_cnt};
        q.push_back(e);
        if (eb) begin m_sa = 0; m_sb = 0; end
        else begin m_sa = fwd_src(rs1); m_sb = fwd_src(rs2); end
`ifdef STALL_CNT_EN
        if (es && m_cnt != 32'hFFFF_FFFF) m_cnt++;
`endif
        hist[1] = hist[0];
        if (eb) hist[0] = '{0, 0, 0, 0};
        else    hist[0] = '{v, rd, rw, mr};
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle that has a recorded expectation is checked mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall",       32'(stall),     32'(e.stall));
            chk("bubble_ex",   32'(bubble_ex), 32'(e.bub));
            chk("fwd_a_sel",   32'(fwd_a_sel), 32'(e.sa));
            chk("fwd_b_sel",   32'(fwd_b_sel), 32'(e.sb));
            chk("stall_count", stall_count,    e.cnt);
        end
    end

    initial begin
        reset = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_reg_write = 0; id_mem_read = 0; flush = 0;
        model_reset();
        #1;
        chk("reset_a", 32'(fwd_a_sel), 0);
        chk("reset_b", 32'(fwd_b_sel), 0);
        chk("reset_stall", 32'(stall), 0);
        chk("reset_bubble", 32'(bubble_ex), 0);
        chk("reset_cnt", stall_count, 0);
        #11 reset = 0;

        // ADD x5 ; SUB x6,x5,x1
        issue(1, 1, 2, 5, 1, 0, 0);
        issue(1, 5, 1, 6, 1, 0, 0);
        nop(); #2;
        chk("exmem_fwd_a", 32'(fwd_a_sel), 2);
        chk("exmem_fwd_b", 32'(fwd_b_sel), 0);
        chk("exmem_nostall", 32'(stall), 0);

        // ADD x5 ; NOP ; OR x7,x1,x5
        nop(); nop();
        issue(1, 1, 2, 5, 1, 0, 0);
        nop();
        issue(1, 1, 5, 7, 1, 0, 0);
        nop(); #2;
        chk("wb_fwd_b", 32'(fwd_b_sel), 1);
        chk("wb_fwd_a", 32'(fwd_a_sel), 0);

        // LW x8 ; ADD x9,x8,x8  (one stall, then both selects 01)
        nop(); nop();
        issue(1, 1, 0, 8, 1, 1, 0);
        issue(1, 8, 8, 9, 1, 0, 0); #2;
        chk("lu_stall", 32'(stall), 1);
        chk("lu_bubble", 32'(bubble_ex), 1);
        issue(1, 8, 8, 9, 1, 0, 0); #2;
        chk("lu_single_stall", 32'(stall), 0);
        nop(); #2;
        chk("lu_fwd_a", 32'(fwd_a_sel), 1);
        chk("lu_fwd_b", 32'(fwd_b_sel), 1);

        // ADD x0 ; SUB x3,x0,x0
        nop(); nop();
        issue(1, 1, 2, 0, 1, 0, 0);
        issue(1, 0, 0, 3, 1, 0, 0);
        nop(); #2;
        chk("x0_a", 32'(fwd_a_sel), 0);
        chk("x0_b", 32'(fwd_b_sel), 0);

        // ADD x4 ; ADD x4 ; AND x2,x4,x4
        nop(); nop();
        issue(1, 1, 2, 4, 1, 0, 0);
        issue(1, 1, 3, 4, 1, 0, 0);
        issue(1, 4, 4, 2, 1, 0, 0);
        nop(); #2;
        chk("young_a", 32'(fwd_a_sel), 2);
        chk("young_b", 32'(fwd_b_sel), 2);

        // LW x8 ; dependent with flush in the same cycle
        nop(); nop();
        issue(1, 1, 0, 8, 1, 1, 0);
        issue(1, 8, 8, 9, 1, 0, 1); #2;
        chk("flush_stall", 32'(stall), 0);
        chk("flush_bubble", 32'(bubble_ex), 1);

        // Randomized traffic on a small register set to provoke hazards
        nop(); nop();
        for (int n = 0; n < 400; n++) begin
            bit v, mr, rw, fl;
            v  = ($urandom_range(0, 7) != 0);
            mr = ($urandom_range(0, 2) == 0);
            rw = mr ? 1'b1 : ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 9) == 0);
            issue(v, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rw, mr, fl);
        end

        // Reset while a stall is asserted
        nop(); nop();
        issue(1, 1, 0, 8, 1, 1, 0);
        issue(1, 8, 1, 9, 1, 0, 0); #1;
        chk("pre_reset_stall", 32'(stall), 1);
        reset = 1; #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_bubble", 32'(bubble_ex), 0);
        chk("rst_a", 32'(fwd_a_sel), 0);
        chk("rst_b", 32'(fwd_b_sel), 0);
        chk("rst_cnt", stall_count, 0);
        q.delete();
        model_reset();
        id_valid = 0;
        @(negedge clk); reset = 0;

        // Same dependent instruction after reset: nothing pending, no stall
        issue(1, 8, 1, 9, 1, 0, 0);
        repeat (3) nop();
        @(negedge clk); @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
